// File: rtl/triang_inv_col_to_row.sv
// rtl/triang_inv_col_to_row.sv - column-to-row reorder buffer for the triangular inverse
// Fills SIZE inverse columns into a flop buffer, then drains them as SIZE rows.
module triang_inv_col_to_row #(
  parameter int SIZE  = 8,
  parameter int WIDTH = 64
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      flush_i,
  input  logic [SIZE*2*WIDTH-1:0]   inv_col_i,
  input  logic                      inv_col_valid_i,
  output logic                      inv_col_ready_o,
  output logic [SIZE*2*WIDTH-1:0]   row_o,
  output logic [$clog2(SIZE)-1:0]   row_addr_o,
  output logic                      row_valid_o,
  input  logic                      row_ready_i,
  output logic                      done_o,
  output logic                      busy_o
);

  localparam int AW = $clog2(SIZE);
  localparam int EW = 2 * WIDTH;

  typedef enum logic {
    ST_FILL  = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [AW-1:0] r_col_cnt;
  logic [AW-1:0] w_col_cnt_nxt;
  logic [AW-1:0] r_row_cnt;
  logic [AW-1:0] w_row_cnt_nxt;
  logic          r_done;
  logic          w_done_nxt;
  logic [EW-1:0] r_buf [SIZE][SIZE];

  logic w_in_ready;
  logic w_row_valid;
  logic w_col_hs;
  logic w_row_hs;

  // Every visible output is forced idle while reset is held, even before the flops clear.
  assign w_in_ready  = (r_state == ST_FILL)  & ~rst_i;
  assign w_row_valid = (r_state == ST_DRAIN) & ~rst_i;
  assign w_col_hs    = inv_col_valid_i & w_in_ready;
  assign w_row_hs    = w_row_valid & row_ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= ST_FILL;
      r_col_cnt <= '0;
      r_row_cnt <= '0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_col_cnt <= w_col_cnt_nxt;
      r_row_cnt <= w_row_cnt_nxt;
      r_done    <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_col_cnt_nxt = r_col_cnt;
    w_row_cnt_nxt = r_row_cnt;
    w_done_nxt    = 1'b0;
    case (r_state)
      ST_FILL: begin
        if (w_col_hs) begin
          w_col_cnt_nxt = r_col_cnt + AW'(1);
          if (r_col_cnt == AW'(SIZE - 1)) begin
            w_state_nxt = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (w_row_hs) begin
          w_row_cnt_nxt = r_row_cnt + AW'(1);
          if (r_row_cnt == AW'(SIZE - 1)) begin
            w_state_nxt = ST_FILL;
            w_done_nxt  = 1'b1;
          end
        end
      end
      default: w_state_nxt = ST_FILL;
    endcase
    // Flush beats any handshake in the same cycle and suppresses the done pulse.
    if (flush_i) begin
      w_state_nxt   = ST_FILL;
      w_col_cnt_nxt = '0;
      w_row_cnt_nxt = '0;
      w_done_nxt    = 1'b0;
    end
  end

  // Words 2r and 2r+1 are adjacent, so {imag, real} of row r is one contiguous slice.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int r = 0; r < SIZE; r++) begin
        for (int c = 0; c < SIZE; c++) begin
          r_buf[r][c] <= '0;
        end
      end
    end else if (w_col_hs && !flush_i) begin
      for (int r = 0; r < SIZE; r++) begin
        r_buf[r][r_col_cnt] <= inv_col_i[2*r*WIDTH +: EW];
      end
    end
  end

  always_comb begin
    row_o = '0;
    if (!rst_i) begin
      for (int j = 0; j < SIZE; j++) begin
        row_o[j*EW +: EW] = r_buf[r_row_cnt][j];
      end
    end
  end

  assign row_addr_o      = rst_i ? '0 : r_row_cnt;
  assign row_valid_o     = w_row_valid;
  assign inv_col_ready_o = w_in_ready;
  assign done_o          = r_done & ~rst_i;
  assign busy_o          = ~rst_i & ((r_state == ST_DRAIN) | (r_col_cnt != '0));

endmodule

// File: tb/tb_triang_inv_col_to_row.sv
// tb/tb_triang_inv_col_to_row.sv - directed bench for triang_inv_col_to_row
// Table of per-cycle vectors plus hand sequences for reset, flush and full matrices.
module tb_triang_inv_col_to_row;

  localparam int SIZE  = 8;
  localparam int WIDTH = 64;
  localparam int AW    = 3;
  localparam int EW    = 2 * WIDTH;
  localparam int BW    = SIZE * 2 * WIDTH;
  localparam logic [63:0] ONE = 64'h3FF0_0000_0000_0000;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic [BW-1:0] inv_col;
  logic          col_valid;
  logic          col_ready;
  logic [BW-1:0] row;
  logic [AW-1:0] row_addr;
  logic          row_valid;
  logic          row_ready;
  logic          done;
  logic          busy;

  int n_err = 0;
  int n_chk = 0;

  typedef struct {
    bit v;
    int col;
    bit rdy;
    bit fl;
    bit e_ir;
    bit e_rv;
    int e_addr;
    bit e_done;
    bit e_busy;
  } vec_t;

  vec_t tbl[$];

  always #5 clk = ~clk;

  triang_inv_col_to_row #(.SIZE(SIZE), .WIDTH(WIDTH)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .flush_i         (flush),
    .inv_col_i       (inv_col),
    .inv_col_valid_i (col_valid),
    .inv_col_ready_o (col_ready),
    .row_o           (row),
    .row_addr_o      (row_addr),
    .row_valid_o     (row_valid),
    .row_ready_i     (row_ready),
    .done_o          (done),
    .busy_o          (busy)
  );

  // kind 0: identity, 1: position tag / ~tag, 2: NaN on diagonal, -0 above, zero below.
  function automatic logic [63:0] elem(int kind, int c, int r, bit im);
    logic [63:0] t;
    t = {40'h0, 8'(c), 8'(r), 8'h00};
    case (kind)
      0: return (im || r != c) ? 64'h0 : ONE;
      1: return im ? ~t : t;
      default: begin
        if (im) return {8'hA5, 40'h0, 8'(c), 8'(r)};
        if (r > c) return 64'h0;
        if (r == c) return 64'h7FF8_0000_0000_0000 | 64'(c);
        return 64'h8000_0000_0000_0000;
      end
    endcase
  endfunction

  function automatic logic [BW-1:0] build_col(int kind, int c);
    logic [BW-1:0] col;
    col = '0;
    for (int r = 0; r < SIZE; r++) begin
      col[2*r*WIDTH +: WIDTH]     = elem(kind, c, r, 1'b0);
      col[(2*r+1)*WIDTH +: WIDTH] = elem(kind, c, r, 1'b1);
    end
    return col;
  endfunction

  task automatic chk1(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chkw(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_row(input int kind, input int r);
    for (int j = 0; j < SIZE; j++) begin
      chkw($sformatf("row%0d el%0d", r, j), row[j*EW +: EW],
           {elem(kind, j, r, 1'b1), elem(kind, j, r, 1'b0)});
    end
  endtask

  task automatic check_row_zero(input string name);
    for (int j = 0; j < SIZE; j++) begin
      chkw($sformatf("%s el%0d", name, j), row[j*EW +: EW], '0);
    end
  endtask

  task automatic drive(input logic v, input logic [BW-1:0] col, input logic rdy,
                       input logic fl, input logic rs);
    @(negedge clk);
    col_valid = v;
    inv_col   = col;
    row_ready = rdy;
    flush     = fl;
    rst       = rs;
    #1;
  endtask

  task automatic run_matrix(input int kind);
    for (int c = 0; c < SIZE; c++) begin
      drive(1'b1, build_col(kind, c), 1'b1, 1'b0, 1'b0);
      chk1($sformatf("m%0d fill ready", kind), col_ready, 1'b1);
      chk1($sformatf("m%0d fill row_valid", kind), row_valid, 1'b0);
    end
    for (int r = 0; r < SIZE; r++) begin
      drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
      chk1($sformatf("m%0d drain row_valid", kind), row_valid, 1'b1);
      chkw($sformatf("m%0d drain addr", kind), EW'(row_addr), EW'(r));
      check_row(kind, r);
      chk1($sformatf("m%0d drain done", kind), done, 1'b0);
    end
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk1($sformatf("m%0d done pulse", kind), done, 1'b1);
    chk1($sformatf("m%0d ready after", kind), col_ready, 1'b1);
    chk1($sformatf("m%0d row_valid after", kind), row_valid, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk1($sformatf("m%0d done drop", kind), done, 1'b0);
  endtask

  task automatic add(input bit v, input int col, input bit rdy, input bit fl, input bit e_ir,
                     input bit e_rv, input int e_addr, input bit e_done, input bit e_busy);
    vec_t t;
    t.v = v; t.col = col; t.rdy = rdy; t.fl = fl; t.e_ir = e_ir;
    t.e_rv = e_rv; t.e_addr = e_addr; t.e_done = e_done; t.e_busy = e_busy;
    tbl.push_back(t);
  endtask

  initial begin
    // Bubbled fill (valid on even cycles, bogus data on odd), then drain with ready 1,0,0,1
    // and input valid held high, accepted only on the done cycle, then flushed.
    add(1, 0, 1, 0, 1, 0, 0, 0, 0);
    for (int c = 1; c < SIZE; c++) begin
      add(0, 7, 1, 0, 1, 0, 0, 0, 1);
      add(1, c, 1, 0, 1, 0, 0, 0, 1);
    end
    add(1, 0, 1, 0, 0, 1, 0, 0, 1);
    add(1, 0, 0, 0, 0, 1, 1, 0, 1);
    add(1, 0, 0, 0, 0, 1, 1, 0, 1);
    add(1, 0, 1, 0, 0, 1, 1, 0, 1);
    add(1, 0, 1, 0, 0, 1, 2, 0, 1);
    add(1, 0, 0, 0, 0, 1, 3, 0, 1);
    add(1, 0, 0, 0, 0, 1, 3, 0, 1);
    add(1, 0, 1, 0, 0, 1, 3, 0, 1);
    add(1, 0, 1, 0, 0, 1, 4, 0, 1);
    add(1, 0, 0, 0, 0, 1, 5, 0, 1);
    add(1, 0, 0, 0, 0, 1, 5, 0, 1);
    add(1, 0, 1, 0, 0, 1, 5, 0, 1);
    add(1, 0, 1, 0, 0, 1, 6, 0, 1);
    add(1, 0, 0, 0, 0, 1, 7, 0, 1);
    add(1, 0, 0, 0, 0, 1, 7, 0, 1);
    add(1, 0, 1, 0, 0, 1, 7, 0, 1);
    add(1, 0, 1, 0, 1, 0, 0, 1, 0);
    add(0, 7, 1, 0, 1, 0, 0, 0, 1);
    add(0, 7, 1, 1, 1, 0, 0, 0, 1);
    add(0, 7, 1, 0, 1, 0, 0, 0, 0);

    rst = 1'b1; flush = 1'b0; col_valid = 1'b1; row_ready = 1'b0; inv_col = '0;

    // Reset state, with a column offered during reset.
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, build_col(1, 0), 1'b1, 1'b0, 1'b1);
      chk1("rst ready", col_ready, 1'b0);
      chk1("rst row_valid", row_valid, 1'b0);
      chk1("rst done", done, 1'b0);
      chk1("rst busy", busy, 1'b0);
      chkw("rst addr", EW'(row_addr), '0);
    end
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk1("post-rst ready", col_ready, 1'b1);
    chk1("post-rst row_valid", row_valid, 1'b0);
    chk1("post-rst busy", busy, 1'b0);
    chk1("post-rst done", done, 1'b0);
    check_row_zero("post-rst row");

    // Identity: columns on cycles 1..8, rows on 9..16, done on 17.
    for (int cyc = 1; cyc <= 17; cyc++) begin
      drive(cyc <= SIZE, (cyc <= SIZE) ? build_col(0, cyc - 1) : '0, 1'b1, 1'b0, 1'b0);
      if (cyc <= SIZE) begin
        chk1($sformatf("id c%0d row_valid", cyc), row_valid, 1'b0);
      end else if (cyc <= 2 * SIZE) begin
        chk1($sformatf("id c%0d row_valid", cyc), row_valid, 1'b1);
        chkw($sformatf("id c%0d addr", cyc), EW'(row_addr), EW'(cyc - SIZE - 1));
        check_row(0, cyc - SIZE - 1);
      end
      chk1($sformatf("id c%0d done", cyc), done, cyc == 17);
    end

    run_matrix(1);
    run_matrix(2);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].v, build_col(1, tbl[i].col), tbl[i].rdy, tbl[i].fl, 1'b0);
      chk1($sformatf("tbl%0d ready", i), col_ready, tbl[i].e_ir);
      chk1($sformatf("tbl%0d row_valid", i), row_valid, tbl[i].e_rv);
      chk1($sformatf("tbl%0d done", i), done, tbl[i].e_done);
      chk1($sformatf("tbl%0d busy", i), busy, tbl[i].e_busy);
      if (tbl[i].e_rv) begin
        chkw($sformatf("tbl%0d addr", i), EW'(row_addr), EW'(tbl[i].e_addr));
        check_row(1, tbl[i].e_addr);
      end
    end

    // Flush after 5 columns, colliding with a 6th handshake, then a full matrix.
    for (int c = 0; c < 5; c++) begin
      drive(1'b1, build_col(1, c), 1'b1, 1'b0, 1'b0);
    end
    drive(1'b1, build_col(1, 5), 1'b1, 1'b1, 1'b0);
    chk1("flush cycle busy", busy, 1'b1);
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk1("after flush busy", busy, 1'b0);
    chk1("after flush row_valid", row_valid, 1'b0);
    chk1("after flush ready", col_ready, 1'b1);
    run_matrix(2);

    // Reset for one cycle while row 3 is presented, then a fresh matrix.
    for (int c = 0; c < SIZE; c++) begin
      drive(1'b1, build_col(1, c), 1'b1, 1'b0, 1'b0);
    end
    for (int r = 0; r < 3; r++) begin
      drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
      chkw("pre-rst addr", EW'(row_addr), EW'(r));
    end
    drive(1'b0, '0, 1'b1, 1'b0, 1'b1);
    chk1("mid-rst row_valid", row_valid, 1'b0);
    chk1("mid-rst ready", col_ready, 1'b0);
    chk1("mid-rst busy", busy, 1'b0);
    chkw("mid-rst addr", EW'(row_addr), '0);
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk1("after mid-rst ready", col_ready, 1'b1);
    chk1("after mid-rst row_valid", row_valid, 1'b0);
    chk1("after mid-rst busy", busy, 1'b0);
    chk1("after mid-rst done", done, 1'b0);
    check_row_zero("after mid-rst row");
    run_matrix(0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
